bin_to_bcdreg: RTL and testbench

//  Result path back to the display: converts a signed two's-complement binary result into the four-digit

---
 rtl/calc_pkg.sv | 17 +
 rtl/bin_to_bcdreg_if.sv | 24 ++
 rtl/bcd_add3.sv | 7 +
 rtl/bin_to_bcdreg.sv | 123 ++++++++++++
 tb/tb_bin_to_bcdreg.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Display codes and the conversion FSM encoding, shared by the calculator's keypad entry,
// binary-to-BCD result path and segment decoder.
package calc_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_MINUS = 4'hB;
  localparam logic [3:0] BCD_ERR   = 4'hE;
  localparam int         BCD_MAX   = 999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABS,
    ST_SHIFT,
    ST_FORMAT
  } state_t;

endpackage

// File: rtl/bin_to_bcdreg_if.sv
// Request/result bundle between the ALU result path and the display digit drivers.
interface bin_to_bcdreg_if #(
  parameter int WIDTH = 11
);
  logic                    start;
  logic signed [WIDTH-1:0] value;
  logic                    busy;
  logic                    done;
  logic                    overflow;
  logic [3:0]              bcd1;
  logic [3:0]              bcd10;
  logic [3:0]              bcd100;
  logic [3:0]              bcdneg;

  modport master (
    output start, value,
    input  busy, done, overflow, bcd1, bcd10, bcd100, bcdneg
  );

  modport slave (
    input  start, value,
    output busy, done, overflow, bcd1, bcd10, bcd100, bcdneg
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcdreg.sv
// Sequential signed binary to 4-position display converter (double-dabble, one bit per cycle)
// with blank-padded digits, adjacent minus sign and an overflow glyph.
module bin_to_bcdreg
  import calc_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input logic            clock,
  input logic            reset_n,
  bin_to_bcdreg_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q, done_q, ovf_out_q;
  logic [3:0]              bcd1_q, bcd10_q, bcd100_q, bcdneg_q;

  logic signed [WIDTH-1:0] val_q;
  logic        [WIDTH:0]   mag_q;
  logic        [11:0]      bcd_q;
  logic                    neg_q, ovf_q;

  logic signed [WIDTH:0]   sval;
  logic        [WIDTH:0]   abs_val;
  logic        [11:0]      adj;
  logic [3:0]              bcd1_d, bcd10_d, bcd100_d, bcdneg_d;

  // Sign-extend first so the most negative input still has an exact magnitude.
  assign sval    = {val_q[WIDTH-1], val_q};
  assign abs_val = val_q[WIDTH-1] ? -sval : sval;

  bcd_add3 u_add3_u (.d_i(bcd_q[3:0]),  .q_o(adj[3:0]));
  bcd_add3 u_add3_t (.d_i(bcd_q[7:4]),  .q_o(adj[7:4]));
  bcd_add3 u_add3_h (.d_i(bcd_q[11:8]), .q_o(adj[11:8]));

  always_ff @(posedge clock) begin
    case (state_q)
      ST_IDLE:  if (bus.start) val_q <= bus.value;
      ST_ABS: begin
        mag_q <= abs_val;
        neg_q <= val_q[WIDTH-1];
        ovf_q <= abs_val > (WIDTH+1)'(BCD_MAX);
        bcd_q <= '0;
      end
      ST_SHIFT: {bcd_q, mag_q} <= {adj, mag_q} << 1;
      default: ;
    endcase
  end

  always_comb begin
    bcdneg_d = BCD_BLANK;
    bcd100_d = BCD_BLANK;
    bcd10_d  = BCD_BLANK;
    bcd1_d   = bcd_q[3:0];
    if (ovf_q) begin
      bcd1_d = BCD_ERR;
    end else if (bcd_q[11:8] != 4'd0) begin
      bcd100_d = bcd_q[11:8];
      bcd10_d  = bcd_q[7:4];
      if (neg_q) bcdneg_d = BCD_MINUS;
    end else if (bcd_q[7:4] != 4'd0) begin
      bcd10_d = bcd_q[7:4];
      if (neg_q) bcd100_d = BCD_MINUS;
    end else if (neg_q) begin
      bcd10_d = BCD_MINUS;
    end
  end

  // The shift register holds the full WIDTH+1 bit magnitude, so SHIFT runs WIDTH+1 cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      bcd1_q    <= BCD_BLANK;
      bcd10_q   <= BCD_BLANK;
      bcd100_q  <= BCD_BLANK;
      bcdneg_q  <= BCD_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_ABS;
            busy_q  <= 1'b1;
          end
        end
        ST_ABS: begin
          state_q <= ST_SHIFT;
          cnt_q   <= '0;
        end
        ST_SHIFT: begin
          if (cnt_q == CNT_W'(WIDTH)) state_q <= ST_FORMAT;
          else                        cnt_q   <= cnt_q + 1'b1;
        end
        ST_FORMAT: begin
          bcd1_q    <= bcd1_d;
          bcd10_q   <= bcd10_d;
          bcd100_q  <= bcd100_d;
          bcdneg_q  <= bcdneg_d;
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_out_q;
  assign bus.bcd1     = bcd1_q;
  assign bus.bcd10    = bcd10_q;
  assign bus.bcd100   = bcd100_q;
  assign bus.bcdneg   = bcdneg_q;

endmodule

// File: tb/tb_bin_to_bcdreg.sv
// Directed bench for bin_to_bcdreg: latency, formatting, overflow, handshake and reset abort.
module tb_bin_to_bcdreg;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] prev_dig;
  logic        prev_ovf;

  bin_to_bcdreg_if #(.WIDTH(11)) bus ();

  bin_to_bcdreg #(.WIDTH(11)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {bus.bcdneg, bus.bcd100, bus.bcd10, bus.bcd1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One conversion; edge 0 is the accepting edge, done is expected after edge 14.
  task automatic run(input string tag, input logic signed [10:0] v,
                     input logic [15:0] exp_dig, input logic exp_ovf);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 7) begin
        chk({tag, "_hold"}, 32'(digits()), 32'(prev_dig));
        chk({tag, "_hovf"}, 32'(bus.overflow), 32'(prev_ovf));
      end
      if (bus.done) break;
    end
    chk({tag, "_lat"}, n, 32'd14);
    chk({tag, "_dig"}, 32'(digits()), 32'(exp_dig));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({tag, "_nbusy"}, 32'(bus.busy), 32'd0);
    prev_dig = exp_dig;
    prev_ovf = exp_ovf;
  endtask

  initial begin
    int dcnt, dedge, dedge2, drop;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.value = '0;
    prev_dig  = 16'hFFFF;
    prev_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig",  32'(digits()), 32'hFFFF);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf",  32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    run("zero",  11'sd0,    16'hFFF0, 1'b0);
    run("p123",  11'sd123,  16'hF123, 1'b0);
    run("m7",    -11'sd7,   16'hFFB7, 1'b0);
    run("m45",   -11'sd45,  16'hFB45, 1'b0);
    run("m999",  -11'sd999, 16'hB999, 1'b0);
    run("p1000", 11'sd1000, 16'hFFFE, 1'b1);
    run("m1024", -11'sd1024, 16'hFFFE, 1'b1);
    run("p5",    11'sd5,    16'hFFF5, 1'b0);

    // Start re-pulsed while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 11'sd321;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    dcnt = 0; dedge = 0; drop = 0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 5) begin bus.start = 1'b1; bus.value = 11'sd999; end
      @(posedge clk);
      @(negedge clk);
      if (e == 5) bus.start = 1'b0;
      if (bus.done) begin dcnt++; dedge = e; end
      if (e < 14 && !bus.busy) drop = 1;
    end
    chk("rp_cnt",  dcnt, 32'd1);
    chk("rp_edge", dedge, 32'd14);
    chk("rp_drop", drop, 32'd0);
    chk("rp_dig",  32'(digits()), 32'hF321);

    // Start held high: back-to-back conversions, one-cycle done pulses.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 11'sd8;
    dcnt = 0; dedge = 0; dedge2 = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        dcnt++;
        if (dcnt == 1) dedge = e;
        else if (dcnt == 2) dedge2 = e;
      end
    end
    bus.start = 1'b0;
    chk("hold_cnt", dcnt, 32'd2);
    chk("hold_e1",  dedge, 32'd14);
    chk("hold_e2",  dedge2, 32'd29);
    chk("hold_dig", 32'(digits()), 32'hFFF8);
    begin
      int w = 0;
      while (!bus.done && w < 40) begin @(negedge clk); w++; end
      chk("hold_drain", 32'(w < 40), 32'd1);
    end

    // Reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 11'sd456;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_dig",  32'(digits()), 32'hFFFF);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_nodone", dcnt, 32'd0);
    prev_dig = 16'hFFFF;
    prev_ovf = 1'b0;
    run("p456", 11'sd456, 16'hF456, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
